// File: rtl/instr_mem_responder_if.sv
// Fetch handshake between the program counter (master) and the instruction
// memory responder (slave): request channel plus response channel.
interface instr_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_instr;
   logic        resp_fault;

   modport master (
      output req_valid, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_instr, resp_fault
   );

   modport slave (
      input  req_valid, req_addr, resp_ready,
      output req_ready, resp_valid, resp_instr, resp_fault
   );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory with a fixed-latency fetch port, branch flush and a
// word-write load port for placing a program image.
module instr_mem_responder #(
   parameter int          MEM_WORDS = 1024,
   parameter int          LATENCY   = 2,
   parameter logic [31:0] FILL_WORD = 32'h0000_0013
) (
   input  logic                         clk,
   input  logic                         rst,
   instr_mem_responder_if.slave         bus,
   input  logic                         flush,
   input  logic                         load_en,
   input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
   input  logic [31:0]                  load_data
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [31:0]   addr_r, addr_s;
   logic [31:0]   instr_r, instr_s;
   logic          fault_r, fault_s;
   logic [31:0]   mem_r [MEM_WORDS];

   logic          req_ready_s;
   logic          accept_s;
   logic [31:0]   cap_addr_s;
   logic          cap_fault_s;
   logic [31:0]   cap_word_s;

   function automatic logic addr_fault_f(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(MEM_WORDS));
   endfunction

   // Request acceptance: open in IDLE, or in RESP when the response is taken.
   always_comb begin
      req_ready_s = 1'b0;
      if (rst || flush) begin
         req_ready_s = 1'b0;
      end else if (state_r == IDLE) begin
         req_ready_s = 1'b1;
      end else if (state_r == RESP) begin
         req_ready_s = bus.resp_ready;
      end else begin
         req_ready_s = 1'b0;
      end
   end

   assign accept_s = bus.req_valid && req_ready_s;

   // Capture path: WAIT reads the latched address, otherwise the live one (LATENCY==1).
   always_comb begin
      cap_addr_s  = bus.req_addr;
      cap_fault_s = 1'b0;
      cap_word_s  = FILL_WORD;
      if (state_r == WAIT) begin
         cap_addr_s = addr_r;
      end else begin
         cap_addr_s = bus.req_addr;
      end
      cap_fault_s = addr_fault_f(cap_addr_s);
      if (cap_fault_s) begin
         cap_word_s = FILL_WORD;
      end else begin
         cap_word_s = mem_r[cap_addr_s[2 +: AW]];
      end
   end

   // Next-state logic; flush overrides everything, a new accept restarts the fetch.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      addr_s  = addr_r;
      instr_s = instr_r;
      fault_s = fault_r;
      if (flush) begin
         state_s = IDLE;
         cnt_s   = '0;
      end else if (accept_s) begin
         addr_s = bus.req_addr;
         if (LATENCY == 1) begin
            instr_s = cap_word_s;
            fault_s = cap_fault_s;
            cnt_s   = '0;
            state_s = RESP;
         end else begin
            cnt_s   = CW'(LATENCY - 1);
            state_s = WAIT;
         end
      end else begin
         case (state_r)
            IDLE: begin
               state_s = IDLE;
            end
            WAIT: begin
               if (cnt_r == CW'(1)) begin
                  instr_s = cap_word_s;
                  fault_s = cap_fault_s;
                  cnt_s   = '0;
                  state_s = RESP;
               end else begin
                  cnt_s = cnt_r - CW'(1);
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  state_s = IDLE;
               end else begin
                  state_s = RESP;
               end
            end
            default: begin
               state_s = IDLE;
               cnt_s   = '0;
            end
         endcase
      end
   end

   // State and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         addr_r  <= 32'd0;
         instr_r <= FILL_WORD;
         fault_r <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         addr_r  <= addr_s;
         instr_r <= instr_s;
         fault_r <= fault_s;
      end
   end

   // Program array; contents survive reset, reads above see the pre-write word.
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem_r[load_addr] <= load_data;
      end
   end

   assign bus.req_ready  = req_ready_s;
   assign bus.resp_valid = (state_r == RESP);
   assign bus.resp_instr = instr_r;
   assign bus.resp_fault = fault_r;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomised and directed bench for instr_mem_responder against a
// transaction-level reference model of the fetch port.
module tb_instr_mem_responder;
   localparam int          MEM_WORDS = 1024;
   localparam int          LATENCY   = 2;
   localparam logic [31:0] FILL      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        load_en;
   logic [9:0]  load_addr;
   logic [31:0] load_data;

   instr_mem_responder_if bus();

   instr_mem_responder #(
      .MEM_WORDS (MEM_WORDS),
      .LATENCY   (LATENCY),
      .FILL_WORD (FILL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .flush     (flush),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data)
   );

   always #5 clk = ~clk;

   // Reference model: memory image, one fetch in flight, one response shown.
   logic [31:0] ref_mem [MEM_WORDS];
   bit          pend;
   int          rem;
   logic [31:0] pend_addr;
   bit          shown;
   logic [31:0] last_word;
   logic        last_fault;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   task automatic capture(input logic [31:0] a);
      bit f;
      f = (a % 4 != 0) || (a / 4 >= MEM_WORDS);
      last_fault = f;
      last_word  = f ? FILL : ref_mem[a[11:2]];
      shown      = 1'b1;
   endtask

   task automatic cycle(input bit rv, input logic [31:0] ad, input bit rr, input bit fl,
                        input bit le, input logic [9:0] la, input logic [31:0] ld,
                        output bit acc);
      bit er;
      @(negedge clk);
      bus.req_valid  = rv;
      bus.req_addr   = ad;
      bus.resp_ready = rr;
      flush          = fl;
      load_en        = le;
      load_addr      = la;
      load_data      = ld;
      #1;
      er = !rst && !fl && !pend && (!shown || rr);
      check("req_ready",  32'(bus.req_ready),  32'(er));
      check("resp_valid", 32'(bus.resp_valid), 32'(shown));
      check("resp_instr", bus.resp_instr,      last_word);
      check("resp_fault", 32'(bus.resp_fault), 32'(last_fault));
      @(posedge clk);
      acc = 1'b0;
      if (!rst) begin
         acc = rv && er;
         if (fl) begin
            pend  = 1'b0;
            shown = 1'b0;
         end else begin
            if (shown && rr) shown = 1'b0;
            if (pend) begin
               rem--;
               if (rem == 0) begin
                  capture(pend_addr);
                  pend = 1'b0;
               end
            end
            if (acc) begin
               if (LATENCY == 1) begin
                  capture(ad);
               end else begin
                  pend      = 1'b1;
                  rem       = LATENCY - 1;
                  pend_addr = ad;
               end
            end
         end
      end
      if (le) ref_mem[la] = ld;
   endtask

   task automatic idle(input int n, input bit rr);
      bit a;
      for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, rr, 1'b0, 1'b0, 10'd0, 32'd0, a);
   endtask

   task automatic fetch_seq(input logic [31:0] addrs [$]);
      bit a;
      int k = 0;
      for (int g = 0; g < 40 && k < addrs.size(); g++) begin
         cycle(1'b1, addrs[k], 1'b1, 1'b0, 1'b0, 10'd0, 32'd0, a);
         if (a) k++;
      end
      check("fetch_seq_accepted", 32'(k), 32'(addrs.size()));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_addr   = 32'd0;
      bus.resp_ready = 1'b0;
      flush          = 1'b0;
      load_en        = 1'b0;
      #1;
      pend       = 1'b0;
      shown      = 1'b0;
      last_word  = FILL;
      last_fault = 1'b0;
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_instr", bus.resp_instr,      FILL);
      check("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
      check("rst_req_ready",  32'(bus.req_ready),  32'd0);
      idle(2, 1'b1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit          a;
      logic [31:0] q [$];
      logic [31:0] ad;
      logic [31:0] prog [4];
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_addr   = 32'd0;
      bus.resp_ready = 1'b0;
      flush          = 1'b0;
      load_en        = 1'b0;
      load_addr      = 10'd0;
      load_data      = 32'd0;
      prog[0] = 32'h0050_0093;
      prog[1] = 32'h0010_8113;
      prog[2] = 32'h0020_81B3;
      prog[3] = 32'h0000_0013;
      do_reset();

      for (int i = 0; i < 16; i++)
         cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 10'(i), (i < 4) ? prog[i] : $urandom, a);

      // Single fetch with exact latency.
      cycle(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0, a);
      idle(3, 1'b1);
      // Back-to-back stream.
      q = '{32'h0, 32'h4, 32'h8, 32'hC};
      fetch_seq(q);
      idle(3, 1'b1);
      // Misaligned and out of range.
      q = '{32'h6, 32'h1000};
      fetch_seq(q);
      idle(3, 1'b1);
      // Backpressure.
      cycle(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, a);
      for (int i = 0; i < 6; i++) cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, a);
      idle(3, 1'b1);
      // Flush in WAIT, then a fresh fetch.
      cycle(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0, a);
      cycle(1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 10'd0, 32'd0, a);
      idle(2, 1'b1);
      cycle(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0, a);
      idle(3, 1'b1);
      // Load on the capture edge returns the old word; the next fetch sees the new one.
      cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0, a);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 10'd0, 32'hDEAD_BEEF, a);
      idle(2, 1'b1);
      cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0, a);
      idle(3, 1'b1);
      // Reset while a fetch is waiting.
      cycle(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0, a);
      do_reset();
      idle(4, 1'b1);

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         case ($urandom % 8)
            0, 1, 2, 3, 4, 5: ad = 32'($urandom % 16) * 32'd4;
            6:                ad = (32'($urandom % 16) * 32'd4) + 32'($urandom_range(1, 3));
            default:          ad = ($urandom % 2 == 0) ? 32'h1000 + 32'($urandom % 64) * 32'd4
                                                        : 32'hFFFF_FFF0;
         endcase
         cycle(1'($urandom % 2), ad, ($urandom % 4) != 0, ($urandom % 16) == 0,
               ($urandom % 8) == 0, 10'($urandom % 16), $urandom, a);
      end
      idle(4, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Instruction-memory responder at the far end of the fetch interface driven by the program counter.
- Accepts one fetch address per handshake and returns the 32-bit instruction word after a fixed, parameterised latency.
- Supports a flush that discards an in-flight fetch when a branch is taken.
- Exposes a word-write load port so benches and boot logic can place a program image in the internal array.

Parameters:
MEM_WORDS, 1024, number of 32-bit instruction words (power of two, >= 2)
LATENCY, 2, cycles from request acceptance to resp_valid (>= 1)
FILL_WORD, 32'h00000013, word returned on fault and at reset (RV32I NOP, addi x0,x0,0)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  fetch request present
req_ready  output  1  responder can accept a request this cycle
req_addr  input  32  byte address of the fetch (PC value)
resp_valid  output  1  resp_instr/resp_fault valid
resp_ready  input  1  consumer takes the response this cycle
resp_instr  output  32  fetched instruction word
resp_fault  output  1  request was misaligned or out of range
flush  input  1  discard any outstanding fetch or response
load_en  input  1  write load_data into the array
load_addr  input  $clog2(MEM_WORDS)  word index for the load write
load_data  input  32  word to write

Behaviour:
- Reset (asynchronous): state=IDLE, wait counter=0, resp_valid=0, resp_instr=FILL_WORD, resp_fault=0. req_ready=0 while rst is high. Array contents are not reset.
- Array: MEM_WORDS x 32. Synchronous write on clk when load_en=1.
- Read index: req_addr[2 +: $clog2(MEM_WORDS)].
- Fault check is evaluated on the latched address. A fault occurs if addr[1:0]!=0 or (addr>>2) >= MEM_WORDS. On a fault, resp_instr=FILL_WORD and resp_fault=1; the array is not read.
- State IDLE:
  - req_ready=1 when flush=0.
  - On req_valid && req_ready: latch req_addr.
  - If LATENCY==1, capture the word and go to RESP.
  - Otherwise set counter=LATENCY-1 and go to WAIT.
- State WAIT:
  - req_ready=0. Counter decrements each cycle.
  - When counter==1, on that edge: capture the word (or fault result) into resp_instr/resp_fault and go to RESP.
- State RESP:
  - resp_valid=1.
  - resp_instr and resp_fault are held stable while resp_ready=0.
  - req_ready = resp_ready && !flush.
  - On resp_ready=1 with no new request: go to IDLE, resp_valid=0 next cycle.
  - On resp_ready=1 with req_valid=1 in the same cycle: the new request is accepted back-to-back and handled as from IDLE.
  - Throughput is therefore 1 fetch per LATENCY cycles, and 1 per cycle when LATENCY==1.
- Latency rule: a request accepted at edge N gives resp_valid=1 in the cycle after edge N+LATENCY-1. That is, LATENCY edges after acceptance, counting the acceptance edge as 1.
- Flush:
  - Highest priority. Synchronous, from any state go to IDLE; resp_valid=0 next cycle.
  - req_ready=0 during the flush cycle, so no request is accepted then.
  - A response shown with resp_ready=1 in a flush cycle still counts as consumed.
- Load/read collision: if load_en writes the index being captured on the same edge, the captured value is the old word (read-before-write). The new word is visible to later fetches.
- Loads are accepted in every state and never stall the fetch path.
- Arithmetic: the counter is $clog2(LATENCY+1) bits wide and never wraps. The address is not incremented internally; the requester owns sequencing.
- Reset asserted mid-operation abandons the fetch immediately; no response is produced after release.

Test Plan:
- Load words 0..3 = 0x00500093, 0x00108113, 0x002081B3, 0x00000013. LATENCY=2. Request addr 0x4 with resp_ready=1. Expect resp_valid exactly 2 edges after acceptance, resp_instr=0x00108113, resp_fault=0.
- Back-to-back requests 0x0, 0x4, 0x8, 0xC with req_valid and resp_ready held high. Expect responses in order 0x00500093, 0x00108113, 0x002081B3, 0x00000013, no loss or duplication, one response per 2 cycles.
- Request 0x6 (misaligned) and 0x1000 (out of range with MEM_WORDS=1024). Expect resp_fault=1 and resp_instr=0x00000013 for both.
- Backpressure: request 0x8, hold resp_ready=0 for 5 cycles. Expect resp_valid=1 and resp_instr=0x002081B3 stable throughout, and req_ready=0 throughout. Raise resp_ready: one handshake, then resp_valid=0.
- Flush: assert flush one cycle after accepting 0x4 (state WAIT). Expect no response, req_ready=0 in the flush cycle, and IDLE with req_ready=1 next cycle. Then request 0xC and expect 0x00000013.
- Collision and reset: accept 0x0, write load_addr=0 with 0xDEADBEEF on the capture edge. Expect 0x00500093, and 0xDEADBEEF on the next fetch of 0x0. Then assert rst in WAIT: resp_valid=0 and resp_instr=0x00000013 immediately, with no response after release.
